// File: rtl/vram_arb_pkg.sv
// Shared types and encodings for the SDRAM controller arbiter.
package vram_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned RCNT_W = 12;
    localparam int unsigned TCNT_W = 4;
    localparam int unsigned VCNT_W = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} arb_state_t;
    typedef enum logic [1:0] {OWN_V, OWN_X, OWN_RF} owner_t;

    localparam logic [SIZE_W-1:0] SZ8  = 2'd0;
    localparam logic [SIZE_W-1:0] SZ16 = 2'd1;
    localparam logic [SIZE_W-1:0] SZ32 = 2'd2;

endpackage

// File: rtl/refresh_timer.sv
// Saturating refresh age counter with registered due/urgent flags.
module refresh_timer
    import vram_arb_pkg::*;
#(
    parameter int unsigned INTERVAL = 810,
    parameter int unsigned URGENT   = 1620
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic rf_due,
    output logic rf_urg
);

    localparam logic [RCNT_W-1:0] RCNT_MAX = '1;

    logic [RCNT_W-1:0] rcnt;
    logic [RCNT_W-1:0] rcnt_nxt;

    always_comb begin
        rcnt_nxt = rcnt;
        if (clear) begin
            rcnt_nxt = '0;
        end else if (rcnt != RCNT_MAX) begin
            rcnt_nxt = rcnt + RCNT_W'(1);
        end
    end

    // Flags are derived from the next count so they always track rcnt exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            rcnt   <= '0;
            rf_due <= 1'b0;
            rf_urg <= 1'b0;
        end else begin
            rcnt   <= rcnt_nxt;
            rf_due <= (rcnt_nxt >= RCNT_W'(INTERVAL));
            rf_urg <= (rcnt_nxt >= RCNT_W'(URGENT));
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Two-port arbiter in front of the single-port SDRAM controller, with built-in
// refresh scheduling and a start-timeout watchdog.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W           = 23,
    parameter int unsigned REFRESH_INTERVAL = 810,
    parameter int unsigned REFRESH_URGENT   = 1620,
    parameter int unsigned V_BURST_MAX      = 4,
    parameter int unsigned START_TIMEOUT    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              v_req,
    input  logic              v_wr,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic [31:0]       v_din,
    input  logic [1:0]        v_size,
    output logic              v_ack,
    output logic [31:0]       v_dout,
    input  logic              x_req,
    input  logic              x_wr,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [31:0]       x_din,
    input  logic [1:0]        x_size,
    output logic              x_ack,
    output logic [31:0]       x_dout,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_refresh,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [1:0]        mem_size,
    input  logic              mem_busy,
    input  logic [31:0]       mem_dout,
    output logic              mem_fail
);

    arb_state_t          state;
    owner_t              owner;
    logic                is_wr;
    logic [TCNT_W-1:0]   tcnt;
    logic [VCNT_W-1:0]   vcount;
    logic                rf_due;
    logic                rf_urg;
    logic                grant_c;
    owner_t              grant_own_c;
    logic                timeout_c;
    logic                done_c;

    refresh_timer #(
        .INTERVAL (REFRESH_INTERVAL),
        .URGENT   (REFRESH_URGENT)
    ) u_refresh_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (mem_refresh),
        .rf_due (rf_due),
        .rf_urg (rf_urg)
    );

    // Fixed-priority grant; X is forced once V has had V_BURST_MAX turns in a row.
    always_comb begin
        grant_c     = 1'b0;
        grant_own_c = OWN_V;
        if (state == IDLE && !mem_busy) begin
            if (rf_urg) begin
                grant_c     = 1'b1;
                grant_own_c = OWN_RF;
            end else if (x_req && vcount == VCNT_W'(V_BURST_MAX)) begin
                grant_c     = 1'b1;
                grant_own_c = OWN_X;
            end else if (v_req) begin
                grant_c     = 1'b1;
                grant_own_c = OWN_V;
            end else if (x_req) begin
                grant_c     = 1'b1;
                grant_own_c = OWN_X;
            end else if (rf_due) begin
                grant_c     = 1'b1;
                grant_own_c = OWN_RF;
            end
        end
    end

    assign timeout_c = (state == WAIT_START) && !mem_busy
                       && (tcnt == TCNT_W'(START_TIMEOUT - 1));
    assign done_c    = timeout_c || ((state == WAIT_DONE) && !mem_busy);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_V;
            is_wr       <= 1'b0;
            tcnt        <= '0;
            vcount      <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_refresh <= 1'b0;
            mem_addr    <= '0;
            mem_din     <= '0;
            mem_size    <= '0;
            mem_fail    <= 1'b0;
            v_ack       <= 1'b0;
            x_ack       <= 1'b0;
            v_dout      <= '0;
            x_dout      <= '0;
        end else begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_refresh <= 1'b0;
            v_ack       <= 1'b0;
            x_ack       <= 1'b0;

            if (!x_req || (grant_c && grant_own_c == OWN_X)) begin
                vcount <= '0;
            end else if (grant_c && grant_own_c == OWN_V
                         && vcount != VCNT_W'(V_BURST_MAX)) begin
                vcount <= vcount + VCNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (grant_c) begin
                        owner <= grant_own_c;
                        state <= ISSUE;
                        if (grant_own_c == OWN_V) begin
                            is_wr    <= v_wr;
                            mem_addr <= v_addr;
                            mem_din  <= v_din;
                            mem_size <= v_size;
                        end else if (grant_own_c == OWN_X) begin
                            is_wr    <= x_wr;
                            mem_addr <= x_addr;
                            mem_din  <= x_din;
                            mem_size <= x_size;
                        end else begin
                            is_wr <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    mem_read    <= (owner != OWN_RF) && !is_wr;
                    mem_write   <= (owner != OWN_RF) && is_wr;
                    mem_refresh <= (owner == OWN_RF);
                    tcnt        <= '0;
                    state       <= WAIT_START;
                end
                WAIT_START: begin
                    if (mem_busy) begin
                        state <= WAIT_DONE;
                    end else if (timeout_c) begin
                        mem_fail <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!mem_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Completion (normal or timed out) acks the owner; refresh is silent.
            if (done_c) begin
                if (owner == OWN_V) begin
                    v_ack <= 1'b1;
                    if (!is_wr) begin
                        v_dout <= mem_dout;
                    end
                end else if (owner == OWN_X) begin
                    x_ack <= 1'b1;
                    if (!is_wr) begin
                        x_dout <= mem_dout;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: requester drivers, SDRAM controller model,
// strobe/ack monitors checking against expected transactions.
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned RF_URG = 1620;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       din;
        logic [1:0]        size;
        logic [31:0]       rdata;
    } xfer_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              v_req = 1'b0, v_wr = 1'b0;
    logic [ADDR_W-1:0] v_addr = '0;
    logic [31:0]       v_din = '0;
    logic [1:0]        v_size = '0;
    logic              v_ack;
    logic [31:0]       v_dout;
    logic              x_req = 1'b0, x_wr = 1'b0;
    logic [ADDR_W-1:0] x_addr = '0;
    logic [31:0]       x_din = '0;
    logic [1:0]        x_size = '0;
    logic              x_ack;
    logic [31:0]       x_dout;
    logic              mem_read, mem_write, mem_refresh, mem_fail;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [1:0]        mem_size;
    logic              mem_busy = 1'b0;
    logic [31:0]       mem_dout = '0;

    vram_arbiter dut (
        .clk(clk), .reset(reset),
        .v_req(v_req), .v_wr(v_wr), .v_addr(v_addr), .v_din(v_din), .v_size(v_size),
        .v_ack(v_ack), .v_dout(v_dout),
        .x_req(x_req), .x_wr(x_wr), .x_addr(x_addr), .x_din(x_din), .x_size(x_size),
        .x_ack(x_ack), .x_dout(x_dout),
        .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_size(mem_size),
        .mem_busy(mem_busy), .mem_dout(mem_dout), .mem_fail(mem_fail)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    xfer_t       v_pend[$], x_pend[$], v_sb[$], x_sb[$];
    int          grant_q[$];
    logic        mute = 1'b0;
    logic [31:0] fill = '0;
    int unsigned bleft = 0;
    int unsigned rcm = 0;
    int unsigned cyc = 0;
    int unsigned t_vreq = 0, t_strobe = 0;
    int unsigned rf_cnt = 0, rf_rcm = 0, late_v = 0;
    int unsigned n_vack = 0, n_xack = 0;
    logic        chk_lat = 1'b0, chk_to = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Controller model: busy rises the cycle after a strobe and stays up 6 cycles.
    always @(posedge clk) begin
        if ((mem_read || mem_write || mem_refresh) && !mute) begin
            mem_busy <= 1'b1;
            bleft    <= 5;
            if (mem_read) mem_dout <= fill ^ 32'(mem_addr);
        end else if (bleft != 0) begin
            bleft <= bleft - 1;
        end else begin
            mem_busy <= 1'b0;
        end
    end

    // Reference refresh age: clears on refresh strobe, saturates at 4095.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset || mem_refresh) rcm <= 0;
        else if (rcm < 4095) rcm <= rcm + 1;
    end

    // Requesters: hold req until ack, then present the next queued transfer.
    always @(negedge clk) begin
        if (v_req && v_ack && v_pend.size() != 0) v_pend.delete(0);
        if (v_pend.size() != 0) begin
            if (!v_req) t_vreq = cyc;
            v_req = 1'b1; v_wr = v_pend[0].wr; v_addr = v_pend[0].addr;
            v_din = v_pend[0].din; v_size = v_pend[0].size;
        end else v_req = 1'b0;
        if (x_req && x_ack && x_pend.size() != 0) x_pend.delete(0);
        if (x_pend.size() != 0) begin
            x_req = 1'b1; x_wr = x_pend[0].wr; x_addr = x_pend[0].addr;
            x_din = x_pend[0].din; x_size = x_pend[0].size;
        end else x_req = 1'b0;
    end

    task automatic cmp_cmd(input string port, input xfer_t e);
        check({port, "_addr"}, 64'(mem_addr), 64'(e.addr));
        check({port, "_size"}, 64'(mem_size), 64'(e.size));
        check({port, "_is_write"}, 64'(mem_write), 64'(e.wr));
        if (e.wr) check({port, "_din"}, 64'(mem_din), 64'(e.din));
    endtask

    always @(negedge clk) begin : strobe_mon
        int p;
        if (mem_read || mem_write || mem_refresh)
            check("strobe_onehot", 64'($countones({mem_read, mem_write, mem_refresh})), 64'(1));
        if (mem_refresh) begin
            rf_cnt++;
            rf_rcm = rcm;
        end
        if (mem_read || mem_write) begin
            t_strobe = cyc;
            if (rcm >= RF_URG + 2) late_v++;
            if (grant_q.size() == 0) check("grant_unexpected", 64'(1), 64'(0));
            else begin
                p = grant_q.pop_front();
                if (p == 0) begin
                    if (chk_lat) check("req_to_strobe", 64'(cyc - t_vreq), 64'(2));
                    if (v_sb.size() == 0) check("v_cmd_unexpected", 64'(1), 64'(0));
                    else cmp_cmd("v", v_sb[0]);
                end else begin
                    if (x_sb.size() == 0) check("x_cmd_unexpected", 64'(1), 64'(0));
                    else cmp_cmd("x", x_sb[0]);
                end
            end
        end
    end

    always @(negedge clk) begin : ack_mon
        xfer_t e;
        if (v_ack) begin
            n_vack++;
            if (v_sb.size() == 0) check("v_ack_unexpected", 64'(1), 64'(0));
            else begin
                e = v_sb.pop_front();
                if (!e.wr) check("v_dout", 64'(v_dout), 64'(e.rdata));
                if (chk_to) begin
                    check("timeout_latency", 64'(cyc - t_strobe), 64'(7));
                    check("timeout_fail_flag", 64'(mem_fail), 64'(1));
                end
            end
        end
        if (x_ack) begin
            n_xack++;
            if (x_sb.size() == 0) check("x_ack_unexpected", 64'(1), 64'(0));
            else begin
                e = x_sb.pop_front();
                if (!e.wr) check("x_dout", 64'(x_dout), 64'(e.rdata));
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int port, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] din, input logic [1:0] size);
        xfer_t e;
        e.wr = wr; e.addr = addr; e.din = din; e.size = size;
        e.rdata = fill ^ 32'(addr);
        if (port == 0) begin v_pend.push_back(e); v_sb.push_back(e); end
        else begin x_pend.push_back(e); x_sb.push_back(e); end
        grant_q.push_back(port);
    endtask

    task automatic clear_queues();
        v_pend.delete(); x_pend.delete(); v_sb.delete(); x_sb.delete(); grant_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_queues();
        repeat (3) sync();
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int n = 0;
        while ((v_sb.size() + x_sb.size()) != 0 && n < bound) begin
            sync();
            n++;
        end
        check({tag, "_outstanding"}, 64'(v_sb.size() + x_sb.size()), 64'(0));
        repeat (3) sync();
    endtask

    task automatic wait_refresh(input string tag, input int bound);
        int unsigned start = rf_cnt;
        int n = 0;
        while (rf_cnt == start && n < bound) begin
            sync();
            n++;
        end
        check({tag, "_seen"}, 64'(rf_cnt != start), 64'(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        do_reset();
        // Reset state
        check("rst_strobes", 64'({mem_read, mem_write, mem_refresh}), 64'(0));
        check("rst_acks_fail", 64'({v_ack, x_ack, mem_fail}), 64'(0));
        check("rst_mem_regs", 64'({mem_addr, mem_size} | 25'(mem_din)), 64'(0));
        check("rst_douts", 64'(v_dout | x_dout), 64'(0));

        // Single V read, latency and data
        n_vack = 0; n_xack = 0; chk_lat = 1'b1;
        fill = 32'hDEADBEEF ^ 32'h0000_0123;
        post(0, 1'b0, 23'h000123, 32'h0, SZ32);
        wait_drain("single_read", 40);
        chk_lat = 1'b0;
        check("single_v_acks", 64'(n_vack), 64'(1));
        check("single_no_x_ack", 64'(n_xack), 64'(0));
        check("single_dout_held", 64'(v_dout), 64'(32'hDEADBEEF));

        // Idle refresh twice: second one proves the counter cleared
        wait_refresh("rf_idle1", 900);
        check("rf_idle1_age", 64'(rf_rcm >= 811 && rf_rcm <= 812), 64'(1));
        wait_refresh("rf_idle2", 900);
        check("rf_idle2_age", 64'(rf_rcm >= 811 && rf_rcm <= 812), 64'(1));

        // V/X contention: V x4, X, V x4, X, V
        do_reset();
        n_vack = 0; n_xack = 0;
        fill = 32'hA5A5_0000;
        clear_queues();
        for (int i = 0; i < 9; i++) begin
            v_pend.push_back(xfer_t'({i[0], 23'(23'h1000 + i), 32'(32'hC0DE0000 + i), SZ16,
                                      fill ^ 32'(23'h1000 + i)}));
            v_sb.push_back(v_pend[i]);
        end
        for (int i = 0; i < 2; i++) begin
            x_pend.push_back(xfer_t'({1'b0, 23'(23'h2000 + i), 32'h0, SZ32,
                                      fill ^ 32'(23'h2000 + i)}));
            x_sb.push_back(x_pend[i]);
        end
        for (int i = 0; i < 11; i++) grant_q.push_back((i == 4 || i == 9) ? 1 : 0);
        wait_drain("contention", 300);
        check("contention_v_acks", 64'(n_vack), 64'(9));
        check("contention_x_acks", 64'(n_xack), 64'(2));
        check("contention_grants_left", 64'(grant_q.size()), 64'(0));

        // Start timeout: busy never rises, then the next request still completes
        mute = 1'b1; chk_to = 1'b1;
        post(0, 1'b1, 23'h0ABCDE, 32'h12345678, SZ16);
        wait_drain("timeout", 40);
        mute = 1'b0; chk_to = 1'b0;
        fill = 32'h0F0F_1234;
        post(1, 1'b0, 23'h003333, 32'h0, SZ8);
        wait_drain("after_timeout", 40);
        check("fail_sticky", 64'(mem_fail), 64'(1));

        // Reset in WAIT_DONE: no ack, everything cleared
        post(0, 1'b0, 23'h004444, 32'h0, SZ32);
        for (int n = 0; n < 20 && !mem_busy; n++) sync();
        check("rst_mid_busy_seen", 64'(mem_busy), 64'(1));
        sync();
        reset = 1'b1;
        clear_queues();
        sync();
        check("rst_mid_strobes", 64'({mem_read, mem_write, mem_refresh}), 64'(0));
        check("rst_mid_acks_fail", 64'({v_ack, x_ack, mem_fail}), 64'(0));
        check("rst_mid_mem_regs", 64'({mem_addr, mem_size} | 25'(mem_din)), 64'(0));
        check("rst_mid_douts", 64'(v_dout | x_dout), 64'(0));
        sync();
        reset = 1'b0;
        repeat (10) sync();
        post(1, 1'b1, 23'h7FFFFF, 32'hCAFEF00D, SZ32);
        wait_drain("post_reset_x_write", 40);

        // Urgent refresh pre-empts a continuously requesting V
        do_reset();
        late_v = 0;
        fill = 32'h5555_AAAA;
        for (int i = 0; i < 180; i++) post(0, 1'b0, 23'(23'h010000 + i), 32'h0, SZ32);
        wait_refresh("rf_urgent", 2500);
        check("rf_urgent_age", 64'(rf_rcm >= 1621 && rf_rcm <= 1640), 64'(1));
        check("rf_urgent_no_late_v", 64'(late_v), 64'(0));
        wait_drain("urgent_tail", 3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
